// File: rtl/lcd_text_engine.sv
// rtl/lcd_text_engine.sv - HD44780 4-bit byte-stream text engine with power-on init, cursor tracking and auto-wrap
module lcd_text_engine #(
    parameter int CLK_FREQ      = 50000000,
    parameter int COLS          = 16,
    parameter int ROWS          = 2,
    parameter int E_HIGH_CYCLES = 12,
    localparam int RW           = (ROWS > 2) ? 2 : 1,
    localparam int CLW          = $clog2(COLS + 1)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_byte,
    input  logic           in_cmd,
    output logic [4:0]     LCD_D,
    output logic           LCD_E,
    output logic           init_done,
    output logic [RW-1:0]  cursor_row,
    output logic [CLW-1:0] cursor_col
);
    localparam int T_US = CLK_FREQ / 1000000;
    localparam int CW   = $clog2(15000 * T_US + 1);

    if (!(ROWS == 1 || ROWS == 2 || ROWS == 4)) begin : g_bad_rows
        $error("lcd_text_engine: ROWS must be 1, 2 or 4");
    end

    typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_SEND, S_WRAP} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EHI, PH_WAIT} phase_t;

    localparam logic [CW-1:0] E_LOAD   = CW'(E_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] PWR_LOAD = CW'(15000 * T_US - 1);

    // Counters load (length - 1) and expire when they reach zero.
    function automatic logic [CW-1:0] wait_load(input int us);
        return CW'(us * T_US - 1);
    endfunction

    function automatic logic [3:0] init_nib(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: return 4'h3;
            4'd3, 4'd4:       return 4'h2;
            4'd5:             return (ROWS == 1) ? 4'h0 : 4'h8;
            4'd7:             return 4'h8;
            4'd9:             return 4'h1;
            4'd11:            return 4'h6;
            4'd13:            return 4'hC;
            default:          return 4'h0;
        endcase
    endfunction

    function automatic logic [CW-1:0] init_wait(input logic [3:0] idx);
        case (idx)
            4'd0:                     return wait_load(4100);
            4'd1, 4'd2, 4'd3:         return wait_load(100);
            4'd9:                     return wait_load(3000);
            4'd5, 4'd7, 4'd11, 4'd13: return wait_load(53);
            default:                  return wait_load(10);
        endcase
    endfunction

    function automatic logic [7:0] ddram(input logic [RW-1:0] r, input logic [CLW-1:0] c);
        logic [7:0] off;
        case (int'(r))
            0:       off = 8'h00;
            1:       off = 8'h40;
            2:       off = 8'(COLS);
            default: off = 8'(8'h40 + COLS);
        endcase
        return 8'h80 | (off + 8'(c));
    endfunction

    function automatic logic [RW-1:0] row_next(input logic [RW-1:0] r);
        if (int'(r) == ROWS - 1) return '0;
        return r + 1'b1;
    endfunction

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     byte_q, byte_d;
    logic           rs_q, rs_d, long_q, long_d, wrap_q, wrap_d;
    logic [RW-1:0]  prow_q, prow_d, row_q, row_d;
    logic [CLW-1:0] pcol_q, pcol_d, col_q, col_d;
    logic [4:0]     lcd_d_q, lcd_d_d;
    logic           lcd_e_q, lcd_e_d, done_q, done_d;

    logic [7:0]     dec_byte;
    logic           dec_rs, dec_long, dec_wrap;
    logic [RW-1:0]  dec_row;
    logic [CLW-1:0] dec_col;
    logic [RW-1:0]  wrap_row;
    logic [7:0]     wrap_byte;
    logic           start_nib, wait_done;
    logic [4:0]     start_val;
    logic [CW-1:0]  cur_wait;

    assign wrap_row  = row_next(prow_q);
    assign wrap_byte = ddram(wrap_row, '0);

    // Translate an incoming byte into the instruction/data to emit and the cursor it leaves behind.
    always_comb begin
        dec_byte = in_byte;
        dec_rs   = 1'b0;
        dec_long = 1'b0;
        dec_wrap = 1'b0;
        dec_row  = row_q;
        dec_col  = col_q;
        if (in_cmd) begin
            if (in_byte inside {8'h01, 8'h02, 8'h03}) begin
                dec_long = 1'b1;
                dec_row  = '0;
                dec_col  = '0;
            end
        end else begin
            case (in_byte)
                8'h0A: begin
                    dec_row  = row_next(row_q);
                    dec_col  = '0;
                    dec_byte = ddram(row_next(row_q), '0);
                end
                8'h0D: begin
                    dec_col  = '0;
                    dec_byte = ddram(row_q, '0);
                end
                8'h0C: begin
                    dec_byte = 8'h01;
                    dec_long = 1'b1;
                    dec_row  = '0;
                    dec_col  = '0;
                end
                default: begin
                    dec_rs   = 1'b1;
                    dec_col  = col_q + 1'b1;
                    dec_wrap = (int'(col_q) + 1 == COLS);
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        rs_d      = rs_q;
        long_d    = long_q;
        wrap_d    = wrap_q;
        prow_d    = prow_q;
        pcol_d    = pcol_q;
        row_d     = row_q;
        col_d     = col_q;
        lcd_d_d   = lcd_d_q;
        lcd_e_d   = lcd_e_q;
        done_d    = done_q;
        start_nib = 1'b0;
        start_val = 5'd0;
        cur_wait  = (idx_q[0] == 1'b0) ? wait_load(10) : (long_q ? wait_load(3000) : wait_load(53));
        if (state_q == S_INIT) cur_wait = init_wait(idx_q);
        wait_done = (phase_q == PH_WAIT) && (cnt_q == '0);

        if (state_q == S_INIT || state_q == S_SEND || state_q == S_WRAP) begin
            case (phase_q)
                PH_SETUP: begin
                    lcd_e_d = 1'b1;
                    phase_d = PH_EHI;
                    cnt_d   = E_LOAD;
                end
                PH_EHI: begin
                    if (cnt_q == '0) begin
                        lcd_e_d = 1'b0;
                        phase_d = PH_WAIT;
                        cnt_d   = cur_wait;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            endcase
        end

        case (state_q)
            S_PWR: begin
                if (cnt_q == '0) begin
                    state_d   = S_INIT;
                    idx_d     = 4'd0;
                    start_nib = 1'b1;
                    start_val = {1'b0, init_nib(4'd0)};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_INIT: begin
                if (wait_done) begin
                    if (idx_q == 4'd13) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        start_nib = 1'b1;
                        start_val = {1'b0, init_nib(idx_q + 4'd1)};
                    end
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_SEND;
                    idx_d     = 4'd0;
                    byte_d    = dec_byte;
                    rs_d      = dec_rs;
                    long_d    = dec_long;
                    wrap_d    = dec_wrap;
                    prow_d    = dec_row;
                    pcol_d    = dec_col;
                    start_nib = 1'b1;
                    start_val = {dec_rs, dec_byte[7:4]};
                end
            end
            S_SEND, S_WRAP: begin
                if (wait_done) begin
                    if (idx_q == 4'd0) begin
                        idx_d     = 4'd1;
                        start_nib = 1'b1;
                        start_val = {rs_q, byte_q[3:0]};
                    end else begin
                        row_d = prow_q;
                        col_d = pcol_q;
                        // A data write that filled the row chains straight into a set-DDRAM for the next row.
                        if (state_q == S_SEND && wrap_q) begin
                            state_d   = S_WRAP;
                            idx_d     = 4'd0;
                            byte_d    = wrap_byte;
                            rs_d      = 1'b0;
                            long_d    = 1'b0;
                            wrap_d    = 1'b0;
                            prow_d    = wrap_row;
                            pcol_d    = '0;
                            start_nib = 1'b1;
                            start_val = {1'b0, wrap_byte[7:4]};
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_PWR;
        endcase

        if (start_nib) begin
            lcd_d_d = start_val;
            lcd_e_d = 1'b0;
            phase_d = PH_SETUP;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_PWR;
            phase_q <= PH_SETUP;
            cnt_q   <= PWR_LOAD;
            idx_q   <= '0;
            byte_q  <= '0;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
            wrap_q  <= 1'b0;
            prow_q  <= '0;
            pcol_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            lcd_d_q <= '0;
            lcd_e_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
            wrap_q  <= wrap_d;
            prow_q  <= prow_d;
            pcol_q  <= pcol_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lcd_d_q <= lcd_d_d;
            lcd_e_q <= lcd_e_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign LCD_D      = lcd_d_q;
    assign LCD_E      = lcd_e_q;
    assign init_done  = done_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
endmodule

// File: tb/tb_lcd_text_engine.sv
// tb/tb_lcd_text_engine.sv - directed self-checking bench for lcd_text_engine
module tb_lcd_text_engine;
    localparam int EH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v1, c1, r1, e1, done1;
    logic [7:0] b1;
    logic [4:0] d1;
    logic [0:0] row1;
    logic [4:0] col1;
    logic       v2, c2, r2, e2, done2;
    logic [7:0] b2;
    logic [4:0] d2;
    logic [1:0] row2;
    logic [4:0] col2;

    lcd_text_engine #(.CLK_FREQ(1000000), .COLS(16), .ROWS(2), .E_HIGH_CYCLES(EH)) dut (
        .CLK(clk), .RST_N(rst_n), .in_valid(v1), .in_ready(r1), .in_byte(b1), .in_cmd(c1),
        .LCD_D(d1), .LCD_E(e1), .init_done(done1), .cursor_row(row1), .cursor_col(col1));

    lcd_text_engine #(.CLK_FREQ(1000000), .COLS(20), .ROWS(4), .E_HIGH_CYCLES(EH)) dut4 (
        .CLK(clk), .RST_N(rst_n), .in_valid(v2), .in_ready(r2), .in_byte(b2), .in_cmd(c2),
        .LCD_D(d2), .LCD_E(e2), .init_done(done2), .cursor_row(row2), .cursor_col(col2));

    int cyc;
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int         checks = 0;
    int         errors = 0;
    int         rise_c[$];
    int         fall_c[$];
    logic [4:0] rise_d[$];
    logic [4:0] rise2_d[$];
    logic       pe1 = 1'b0;
    logic       pe2 = 1'b0;

    always @(negedge clk) begin
        if (e1 && !pe1) begin
            rise_c.push_back(cyc);
            rise_d.push_back(d1);
        end
        if (!e1 && pe1) fall_c.push_back(cyc);
        if (e2 && !pe2) rise2_d.push_back(d2);
        pe1 <= e1;
        pe2 <= e2;
    end

    int         init_w [14] = '{4100, 100, 100, 100, 10, 53, 10, 53, 10, 3000, 10, 53, 10, 53};
    logic [3:0] init_n [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};

    function automatic logic rdy(input int which);
        return (which == 0) ? r1 : r2;
    endfunction

    task automatic clear_q();
        rise_c.delete();
        fall_c.delete();
        rise_d.delete();
        rise2_d.delete();
    endtask

    // Offer one byte at the next ready cycle, then wait for in_ready to come back; called at a negedge.
    task automatic send(input int which, input logic [7:0] b, input logic cmd, output int rdy_cyc);
        int n;
        n = 0;
        while (rdy(which) !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
        if (n >= 10000) begin checks++; errors++; $display("FAIL send_wait_ready: in_ready never rose"); end
        if (which == 0) begin v1 = 1'b1; b1 = b; c1 = cmd; end
        else            begin v2 = 1'b1; b2 = b; c2 = cmd; end
        @(negedge clk);
        v1 = 1'b0;
        v2 = 1'b0;
        n = 0;
        while (rdy(which) !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
        if (n >= 10000) begin checks++; errors++; $display("FAIL send_done: in_ready did not return for byte %h", b); end
        rdy_cyc = cyc;
    endtask

    // Release reset, wait for init_done and check the whole init nibble train and its timing.
    task automatic run_init(input string tag);
        int n, done_c, exp_done;
        clear_q();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (done1 !== 1'b1 && n < 30000) begin @(negedge clk); n++; end
        done_c = cyc;
        exp_done = 15000;
        for (int k = 0; k < 14; k++) exp_done += 1 + EH + init_w[k];
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL %s_init_done: got %b required 1", tag, done1); end
        checks++; if (done_c !== exp_done) begin errors++; $display("FAIL %s_ready_latency: got %0d required %0d", tag, done_c, exp_done); end
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL %s_ready_at_done: got %b required 1", tag, r1); end
        checks++; if (rise_c.size() !== 14) begin errors++; $display("FAIL %s_nibble_count: got %0d required 14", tag, rise_c.size()); end
        if (rise_c.size() == 14 && fall_c.size() == 14) begin
            checks++; if (rise_c[0] !== 15001) begin errors++; $display("FAIL %s_pwr_wait: first E at %0d required 15001", tag, rise_c[0]); end
            for (int k = 0; k < 14; k++) begin
                checks++; if (rise_d[k] !== {1'b0, init_n[k]}) begin errors++; $display("FAIL %s_nibble%0d: got %b required %b", tag, k, rise_d[k], {1'b0, init_n[k]}); end
                if (k < 13) begin
                    checks++; if (rise_c[k+1] - rise_c[k] !== 1 + EH + init_w[k]) begin errors++; $display("FAIL %s_gap%0d: got %0d required %0d", tag, k, rise_c[k+1] - rise_c[k], 1 + EH + init_w[k]); end
                end
            end
            checks++; if (done_c - fall_c[13] !== 53) begin errors++; $display("FAIL %s_last_wait: got %0d required 53", tag, done_c - fall_c[13]); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v1 = 1'b0; b1 = 8'h00; c1 = 1'b0;
        v2 = 1'b0; b2 = 8'h00; c2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({d1, e1, r1, done1} !== 8'h00) begin errors++; $display("FAIL reset_outputs: got %b required 0", {d1, e1, r1, done1}); end
        checks++; if ({row1, col1} !== 6'd0) begin errors++; $display("FAIL reset_cursor: got %b required 0", {row1, col1}); end
    endtask

    task automatic test_init();
        run_init("boot");
        checks++; if (done2 !== 1'b1 || r2 !== 1'b1) begin errors++; $display("FAIL boot_rows4_ready: got %b%b required 11", done2, r2); end
    endtask

    task automatic test_char();
        int rc;
        clear_q();
        send(0, 8'h41, 1'b0, rc);
        checks++; if (rise_d.size() !== 2) begin errors++; $display("FAIL char_count: got %0d required 2", rise_d.size()); end
        if (rise_d.size() == 2 && fall_c.size() == 2) begin
            checks++; if (rise_d[0] !== 5'b10100) begin errors++; $display("FAIL char_hi: got %b required 10100", rise_d[0]); end
            checks++; if (rise_d[1] !== 5'b10001) begin errors++; $display("FAIL char_lo: got %b required 10001", rise_d[1]); end
            checks++; if (rise_c[1] - rise_c[0] !== 13) begin errors++; $display("FAIL char_gap: got %0d required 13", rise_c[1] - rise_c[0]); end
            checks++; if (rc - fall_c[1] !== 53) begin errors++; $display("FAIL char_post_wait: got %0d required 53", rc - fall_c[1]); end
        end
        checks++; if (col1 !== 5'd1 || row1 !== 1'b0) begin errors++; $display("FAIL char_cursor: got %0d,%0d required 0,1", row1, col1); end
    endtask

    task automatic test_formfeed();
        int rc;
        clear_q();
        send(0, 8'h0C, 1'b0, rc);
        if (rise_d.size() == 2 && fall_c.size() == 2) begin
            checks++; if (rise_d[0] !== 5'b00000 || rise_d[1] !== 5'b00001) begin errors++; $display("FAIL ff_nibbles: got %b %b required 00000 00001", rise_d[0], rise_d[1]); end
            checks++; if (rc - fall_c[1] !== 3000) begin errors++; $display("FAIL ff_long_wait: got %0d required 3000", rc - fall_c[1]); end
        end else begin
            checks++; errors++; $display("FAIL ff_count: got %0d required 2", rise_d.size());
        end
        checks++; if (col1 !== 5'd0 || row1 !== 1'b0) begin errors++; $display("FAIL ff_cursor: got %0d,%0d required 0,0", row1, col1); end
    endtask

    task automatic test_autowrap();
        int rc;
        for (int pass = 0; pass < 2; pass++) begin
            clear_q();
            for (int i = 0; i < 16; i++) send(0, 8'h61 + 8'(i), 1'b0, rc);
            checks++; if (rise_d.size() !== 34) begin errors++; $display("FAIL wrap%0d_count: got %0d required 34", pass, rise_d.size()); end
            if (rise_d.size() == 34) begin
                checks++; if (rise_d[0] !== 5'b10110 || rise_d[31] !== 5'b10000) begin errors++; $display("FAIL wrap%0d_data: got %b %b required 10110 10000", pass, rise_d[0], rise_d[31]); end
                checks++; if (rise_d[32] !== ((pass == 0) ? 5'b01100 : 5'b01000) || rise_d[33] !== 5'b00000) begin errors++; $display("FAIL wrap%0d_ddram: got %b %b", pass, rise_d[32], rise_d[33]); end
                checks++; if (rise_c[32] - rise_c[31] !== 1 + EH + 53) begin errors++; $display("FAIL wrap%0d_immediate: got %0d required 56", pass, rise_c[32] - rise_c[31]); end
            end
            checks++; if (row1 !== ((pass == 0) ? 1'b1 : 1'b0) || col1 !== 5'd0) begin errors++; $display("FAIL wrap%0d_cursor: got %0d,%0d", pass, row1, col1); end
        end
    endtask

    task automatic test_cr_lf();
        int rc;
        send(0, 8'h0A, 1'b0, rc);
        for (int i = 0; i < 5; i++) send(0, 8'h30 + 8'(i), 1'b0, rc);
        checks++; if (row1 !== 1'b1 || col1 !== 5'd5) begin errors++; $display("FAIL crlf_setup: got %0d,%0d required 1,5", row1, col1); end
        clear_q();
        send(0, 8'h0D, 1'b0, rc);
        checks++; if (rise_d.size() !== 2 || rise_d[0] !== 5'b01100 || rise_d[1] !== 5'b00000) begin errors++; $display("FAIL cr_ddram: got %0d nibbles, first %b", rise_d.size(), rise_d[0]); end
        checks++; if (row1 !== 1'b1 || col1 !== 5'd0) begin errors++; $display("FAIL cr_cursor: got %0d,%0d required 1,0", row1, col1); end
        clear_q();
        send(0, 8'h0A, 1'b0, rc);
        checks++; if (rise_d.size() !== 2 || rise_d[0] !== 5'b01000 || rise_d[1] !== 5'b00000) begin errors++; $display("FAIL lf_ddram: got %0d nibbles, first %b", rise_d.size(), rise_d[0]); end
        checks++; if (row1 !== 1'b0 || col1 !== 5'd0) begin errors++; $display("FAIL lf_cursor: got %0d,%0d required 0,0", row1, col1); end
    endtask

    task automatic test_raw_cmd();
        int rc;
        send(0, 8'h78, 1'b0, rc);
        clear_q();
        send(0, 8'h0F, 1'b1, rc);
        if (rise_d.size() == 2 && fall_c.size() == 2) begin
            checks++; if (rise_d[0] !== 5'b00000 || rise_d[1] !== 5'b01111) begin errors++; $display("FAIL raw_nibbles: got %b %b required 00000 01111", rise_d[0], rise_d[1]); end
            checks++; if (rc - fall_c[1] !== 53) begin errors++; $display("FAIL raw_wait: got %0d required 53", rc - fall_c[1]); end
        end else begin
            checks++; errors++; $display("FAIL raw_count: got %0d required 2", rise_d.size());
        end
        checks++; if (row1 !== 1'b0 || col1 !== 5'd1) begin errors++; $display("FAIL raw_cursor: got %0d,%0d required 0,1", row1, col1); end
        clear_q();
        send(0, 8'h02, 1'b1, rc);
        if (rise_d.size() == 2 && fall_c.size() == 2) begin
            checks++; if (rise_d[1] !== 5'b00010 || rc - fall_c[1] !== 3000) begin errors++; $display("FAIL home_cmd: got %b wait %0d required 00010 wait 3000", rise_d[1], rc - fall_c[1]); end
        end else begin
            checks++; errors++; $display("FAIL home_count: got %0d required 2", rise_d.size());
        end
        checks++; if (col1 !== 5'd0) begin errors++; $display("FAIL home_cursor: got col %0d required 0", col1); end
    endtask

    task automatic test_busy_ignore();
        int n;
        clear_q();
        while (r1 !== 1'b1) @(negedge clk);
        v1 = 1'b1; b1 = 8'h42; c1 = 1'b0;
        @(negedge clk);
        b1 = 8'h5A;
        repeat (30) @(negedge clk);
        v1 = 1'b0;
        n = 0;
        while (r1 !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        checks++; if (rise_d.size() !== 2) begin errors++; $display("FAIL busy_count: got %0d required 2", rise_d.size()); end
        checks++; if (rise_d.size() == 2 && (rise_d[0] !== 5'b10100 || rise_d[1] !== 5'b10010)) begin errors++; $display("FAIL busy_data: got %b %b required 10100 10010", rise_d[0], rise_d[1]); end
        checks++; if (col1 !== 5'd1) begin errors++; $display("FAIL busy_cursor: got col %0d required 1", col1); end
    endtask

    task automatic test_rows4();
        int rc;
        clear_q();
        send(1, 8'h0A, 1'b0, rc);
        checks++; if (rise2_d.size() !== 2 || rise2_d[0] !== 5'b01100 || row2 !== 2'd1) begin errors++; $display("FAIL rows4_lf1: got %0d nibbles first %b row %0d", rise2_d.size(), rise2_d[0], row2); end
        clear_q();
        send(1, 8'h0A, 1'b0, rc);
        checks++; if (rise2_d.size() !== 2 || rise2_d[0] !== 5'b01001 || rise2_d[1] !== 5'b00100) begin errors++; $display("FAIL rows4_lf2: got %0d nibbles %b %b required 01001 00100", rise2_d.size(), rise2_d[0], rise2_d[1]); end
        checks++; if (row2 !== 2'd2 || col2 !== 5'd0) begin errors++; $display("FAIL rows4_cursor: got %0d,%0d required 2,0", row2, col2); end
    endtask

    task automatic test_reset_mid();
        int n;
        while (r1 !== 1'b1) @(negedge clk);
        v1 = 1'b1; b1 = 8'h51; c1 = 1'b0;
        n = 0;
        while (e1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL midreset_e_high: got %b required 1", e1); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({d1, e1, r1, done1} !== 8'h00) begin errors++; $display("FAIL midreset_async: got %b required 0", {d1, e1, r1, done1}); end
        repeat (2) @(negedge clk);
        run_init("replay");
        v1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_char();
        test_formfeed();
        test_autowrap();
        test_cr_lf();
        test_raw_cmd();
        test_busy_ignore();
        test_rows4();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_text_engine.md
# lcd_text_engine

Parametrised HD44780-compatible character-LCD controller in 4-bit mode. It supersedes the one-shot init-plus-string writer with a byte-stream engine. It runs the power-on init sequence autonomously after reset, then accepts characters or raw instructions one byte at a time over a valid/ready handshake. It tracks the cursor, handles control codes, auto-wraps across ROWS×COLS, and drives the LCD pins directly with no separate transfer submodule.

## Interface
- CLK_FREQ, 50000000: clock frequency in Hz. T_US = CLK_FREQ/1000000, integer, ≥1.
- COLS, 16: visible columns. Legal range 8..40.
- ROWS, 2: visible rows. Legal values 1, 2, 4. Any other value is an elaboration error.
- E_HIGH_CYCLES, 12: LCD_E high width in clocks, ≥1.
- CLK  in  1: clock, all logic on rising edge.
- RST_N  in  1: asynchronous, active-low reset.
- in_valid  in  1: byte offered.
- in_ready  out  1: engine accepts a byte this cycle.
- in_byte  in  8: character or instruction.
- in_cmd  in  1: 1 means in_byte is a raw instruction (RS=0); 0 means character/control code.
- LCD_D  out  5: bit 4 = RS, bits 3:0 = DB7..DB4.
- LCD_E  out  1: enable strobe.
- init_done  out  1: init sequence complete. Sticky until reset.
- cursor_row  out  max(1,clog2(ROWS)): tracked row.
- cursor_col  out  clog2(COLS+1): tracked column.

## Operation
- Reset values: LCD_D=0, LCD_E=0, in_ready=0, init_done=0, cursor_row=0, cursor_col=0. Reset asserted at any time aborts everything immediately. After release the full init replays.
- Top FSM: PWR_WAIT → INIT → IDLE → SEND → (WRAP) → IDLE.
- PWR_WAIT: 15000·T_US cycles with LCD_E low.
- INIT nibbles (RS=0) and following waits, in order:
  - 3 (4100 µs), 3 (100 µs), 3 (100 µs), 2 (100 µs)
  - Then bytes: 0x28 (0x20 if ROWS=1), 0x08, 0x01, 0x06, 0x0C.
  - init_done rises the cycle the last wait expires. The FSM enters IDLE in the same cycle.
- Byte transfer: high nibble, 10 µs wait, low nibble, then post-byte wait. Post-byte wait is 3000 µs for instructions 0x01, 0x02, 0x03; 53 µs for everything else.
- IDLE: in_ready=1. A byte is accepted on in_valid & in_ready, latched, and in_ready is 0 from the next cycle.
- in_cmd=1: byte sent with RS=0. Cursor is reset to (0,0) for 0x01/0x02/0x03 and unchanged otherwise.
- in_cmd=0 decode:
  - 0x0A (LF): row=(row+1) mod ROWS, col=0. Emit set-DDRAM.
  - 0x0D (CR): col=0. Emit set-DDRAM for the current row.
  - 0x0C (FF): emit 0x01 with the 3000 µs wait. row=col=0.
  - Any other byte: sent with RS=1, col+1.
- Auto-wrap: if a data write leaves col==COLS, WRAP immediately emits set-DDRAM for row=(row+1) mod ROWS, col=0, before in_ready returns.
- Set-DDRAM = 0x80 | (offset + col). Row offsets: row0 0x00, row1 0x40, row2 COLS, row3 0x40+COLS.
- Cursor outputs update in the cycle the related transfer's final wait expires.

## Timing
- Nibble transfer, cycle 0 = start:
  - Cycle 0: LCD_D driven, LCD_E=0.
  - Cycles 1..E_HIGH_CYCLES: LCD_E=1.
  - Cycle E_HIGH_CYCLES+1: LCD_E=0.
  - The wait counter then runs N·T_US cycles. The next nibble starts the cycle after it expires.
- LCD_D is held stable from cycle 0 until the next nibble's cycle 0.
- Wait counter width is clog2(15000·T_US+1). No wrap is possible.
- in_ready re-asserts the cycle after the final wait of the accepted byte (including WRAP) expires.
- Bytes offered while in_ready=0 are ignored and not latched. in_valid held high is accepted once per IDLE visit.
- Zero-to-ready latency from reset release: sum of all init waits plus per-nibble overhead. This value is fixed and must be computed exactly by the bench.

## Test plan
- Reset release, CLK_FREQ=1000000, E_HIGH_CYCLES=2:
  - No LCD_E for 15000 cycles.
  - Then RS=0 nibbles 3,3,3,2,2,8,0,8,0,1,0,6,0,C with the specified gaps.
  - init_done=1 exactly 53 cycles after the last falling E edge. in_ready=1 the same cycle.
- Char 'A' (0x41) → LCD_D=5'b10100, then 5'b10001. Second nibble starts 13 cycles after the first (1+2+10). in_ready returns 53 cycles after the second E falls. cursor_col=1.
- COLS=16, ROWS=2:
  - 16 chars → row-0 data writes, then nibbles C,0 (RS=0). Row=1, col=0.
  - 16 more chars → 8,0. Row=0.
- At row 1, col 5:
  - 0x0D → 0xC0; col becomes 0, row 1.
  - Then 0x0A → 0x80 (row wraps to 0).
  - ROWS=4, COLS=20: 0x0A from row 1 → 0x94.
- 0x0C → nibbles 0,1 (RS=0), 3000-cycle wait, cursor (0,0). Raw in_cmd=1 0x0F → nibbles 0,F with RS=0, 53-cycle wait, cursor unchanged.
- RST_N low while LCD_E=1 mid-character → LCD_E, LCD_D, in_ready, init_done all 0 asynchronously. After release, the full init replays from PWR_WAIT. A pending in_valid is not sent before init_done.
